// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 stream decrypt core.
package arc4_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    KSA,
    LEN,
    PRGA
  } state_t;

  typedef enum logic [2:0] {
    C1,
    C2,
    C3,
    C4,
    C5
  } phase_t;

  localparam logic [7:0] ASCII_LO   = 8'h20;
  localparam logic [7:0] ASCII_HI   = 8'h7E;
  localparam int         SBOX_DEPTH = 256;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= ASCII_LO) && (b <= ASCII_HI);
  endfunction

endpackage

// File: rtl/arc4_sbox_ram.sv
// 256x8 single-port synchronous RAM holding the ARC4 permutation.
module arc4_sbox_ram
  import arc4_pkg::*;
(
  input  logic       clk,
  input  logic [7:0] addr,
  input  logic [7:0] wrdata,
  input  logic       wren,
  output logic [7:0] q
);

  logic [7:0] mem [0:SBOX_DEPTH-1];

  always_ff @(posedge clk) begin
    if (wren) mem[addr] <= wrdata;
    q <= mem[addr];
  end

endmodule

// File: rtl/arc4_stream_core.sv
// ARC4 decrypt core: init, key schedule and keystream generation over one
// single-port S-box, with a length-prefixed ciphertext/plaintext stream.
module arc4_stream_core
  import arc4_pkg::*;
#(
  parameter int KEY_BYTES   = 3,
  parameter int CHECK_ASCII = 1,
  parameter int MAX_LEN     = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  output logic                   rdy,
  input  logic [8*KEY_BYTES-1:0] key,
  input  logic                   halt,
  input  logic                   ct_valid,
  input  logic [7:0]             ct_data,
  output logic                   ct_ready,
  output logic                   pt_valid,
  output logic [7:0]             pt_data,
  input  logic                   pt_ready,
  output logic                   done,
  output logic                   fail
);

  localparam int            KW        = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KW-1:0] KEY_LAST  = KW'(KEY_BYTES - 1);
  localparam logic [8:0]    LEN_LIMIT = 9'(MAX_LEN);

  state_t        state, state_n;
  phase_t        phase, phase_n;
  logic [7:0]    i, i_n;
  logic [7:0]    j, j_n;
  logic [7:0]    si, si_n;
  logic [7:0]    sj, sj_n;
  logic [7:0]    pad, pad_n;
  logic [7:0]    len, len_n;
  logic [7:0]    cnt, cnt_n;
  logic [KW-1:0] kidx, kidx_n;
  logic [7:0]    key_arr   [KEY_BYTES];
  logic [7:0]    key_arr_n [KEY_BYTES];
  logic          done_n, fail_n, pt_valid_n;
  logic [7:0]    pt_data_n;

  logic [7:0]    ram_addr, ram_wdata, ram_q;
  logic          ram_wren;
  logic [7:0]    t, plain, j_sum;

  arc4_sbox_ram u_sbox (
    .clk    (clk),
    .addr   (ram_addr),
    .wrdata (ram_wdata),
    .wren   (ram_wren),
    .q      (ram_q)
  );

  assign rdy = (state == IDLE);

  // Control state: cleared by reset and by halt alike.
  always_ff @(posedge clk) begin
    if (!rst_n || halt) begin
      state    <= IDLE;
      phase    <= C1;
      done     <= 1'b0;
      fail     <= 1'b0;
      pt_valid <= 1'b0;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      done     <= done_n;
      fail     <= fail_n;
      pt_valid <= pt_valid_n;
    end
  end

  always_ff @(posedge clk) begin
    i       <= i_n;
    j       <= j_n;
    si      <= si_n;
    sj      <= sj_n;
    pad     <= pad_n;
    len     <= len_n;
    cnt     <= cnt_n;
    kidx    <= kidx_n;
    key_arr <= key_arr_n;
    pt_data <= pt_data_n;
  end

  always_comb begin
    state_n    = state;
    phase_n    = phase;
    i_n        = i;
    j_n        = j;
    si_n       = si;
    sj_n       = sj;
    pad_n      = pad;
    len_n      = len;
    cnt_n      = cnt;
    kidx_n     = kidx;
    key_arr_n  = key_arr;
    done_n     = done;
    fail_n     = fail;
    pt_valid_n = pt_valid;
    pt_data_n  = pt_data;
    ram_addr   = i;
    ram_wdata  = i;
    ram_wren   = 1'b0;
    ct_ready   = 1'b0;
    t          = si + sj;
    plain      = pad ^ ct_data;
    j_sum      = j + ram_q;

    if (pt_valid && pt_ready) pt_valid_n = 1'b0;

    case (state)
      IDLE: begin
        if (en) begin
          for (int b = 0; b < KEY_BYTES; b++)
            key_arr_n[b] = key[8*(KEY_BYTES-1-b) +: 8];
          done_n  = 1'b0;
          fail_n  = 1'b0;
          i_n     = 8'd0;
          state_n = INIT;
        end
      end

      INIT: begin
        ram_addr  = i;
        ram_wdata = i;
        ram_wren  = 1'b1;
        i_n       = i + 8'd1;
        if (i == 8'hFF) begin
          state_n = KSA;
          phase_n = C1;
          j_n     = 8'd0;
          kidx_n  = '0;
        end
      end

      KSA: begin
        case (phase)
          C1: begin
            ram_addr = i;
            phase_n  = C2;
          end
          C2: begin
            si_n     = ram_q;
            j_sum    = j + ram_q + key_arr[kidx];
            j_n      = j_sum;
            ram_addr = j_sum;
            phase_n  = C3;
          end
          C3: begin
            sj_n      = ram_q;
            ram_addr  = i;
            ram_wdata = ram_q;
            ram_wren  = 1'b1;
            phase_n   = C4;
          end
          default: begin
            ram_addr  = j;
            ram_wdata = si;
            ram_wren  = 1'b1;
            i_n       = i + 8'd1;
            kidx_n    = (kidx == KEY_LAST) ? '0 : kidx + 1'b1;
            phase_n   = C1;
            if (i == 8'hFF) state_n = LEN;
          end
        endcase
      end

      LEN: begin
        if (phase == C1) begin
          ct_ready = 1'b1;
          if (ct_valid) begin
            len_n = ct_data;
            if ({1'b0, ct_data} > LEN_LIMIT) begin
              fail_n  = 1'b1;
              done_n  = 1'b1;
              state_n = IDLE;
            end else begin
              pt_data_n  = ct_data;
              pt_valid_n = 1'b1;
              phase_n    = C2;
            end
          end
        end else if (pt_ready) begin
          if (len == 8'd0) begin
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            state_n = PRGA;
            phase_n = C1;
            i_n     = 8'd0;
            j_n     = 8'd0;
            cnt_n   = 8'd0;
          end
        end
      end

      PRGA: begin
        case (phase)
          C1: begin
            i_n      = i + 8'd1;
            ram_addr = i + 8'd1;
            phase_n  = C2;
          end
          C2: begin
            si_n     = ram_q;
            j_n      = j_sum;
            ram_addr = j_sum;
            phase_n  = C3;
          end
          // The pad read happens before the swap writes so the single port
          // suffices; C4 patches the pre-swap value for t==i / t==j.
          C3: begin
            sj_n     = ram_q;
            ram_addr = si + ram_q;
            phase_n  = C4;
          end
          C4: begin
            ram_addr  = i;
            ram_wdata = sj;
            ram_wren  = 1'b1;
            if (t == j)      pad_n = si;
            else if (t == i) pad_n = sj;
            else             pad_n = ram_q;
            phase_n = C5;
          end
          default: begin
            ram_addr  = j;
            ram_wdata = si;
            ram_wren  = 1'b1;
            if (cnt == len) begin
              if (pt_valid && pt_ready) begin
                done_n  = 1'b1;
                state_n = IDLE;
              end
            end else if (!pt_valid) begin
              ct_ready = 1'b1;
              if (ct_valid) begin
                cnt_n = cnt + 8'd1;
                if ((CHECK_ASCII != 0) && !is_printable(plain)) begin
                  fail_n  = 1'b1;
                  done_n  = 1'b1;
                  state_n = IDLE;
                end else begin
                  pt_data_n  = plain;
                  pt_valid_n = 1'b1;
                  if ((cnt + 8'd1) != len) phase_n = C1;
                end
              end
            end
          end
        endcase
      end

      default: state_n = IDLE;
    endcase

    if (halt || !rst_n) ct_ready = 1'b0;
  end

endmodule

// File: tb/tb_arc4_stream_core.sv
// Directed bench for arc4_stream_core: known ARC4 vectors, stalls, early
// abort, length limits, halt and reset.
module tb_arc4_stream_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en, halt, sel;
  logic        ct_valid, pt_ready;
  logic [7:0]  ct_data;
  logic [23:0] key_a;
  logic [31:0] key_b;

  logic       rdy_a, ct_ready_a, pt_valid_a, done_a, fail_a;
  logic       rdy_b, ct_ready_b, pt_valid_b, done_b, fail_b;
  logic [7:0] pt_data_a, pt_data_b;
  logic       en_a, en_b;

  logic       rdy, ct_ready, pt_valid, done, fail;
  logic [7:0] pt_data;

  assign en_a     = en & ~sel;
  assign en_b     = en & sel;
  assign rdy      = sel ? rdy_b      : rdy_a;
  assign ct_ready = sel ? ct_ready_b : ct_ready_a;
  assign pt_valid = sel ? pt_valid_b : pt_valid_a;
  assign pt_data  = sel ? pt_data_b  : pt_data_a;
  assign done     = sel ? done_b     : done_a;
  assign fail     = sel ? fail_b     : fail_a;

  arc4_stream_core #(.KEY_BYTES(3), .CHECK_ASCII(1), .MAX_LEN(16)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .rdy(rdy_a), .key(key_a), .halt(halt),
    .ct_valid(ct_valid), .ct_data(ct_data), .ct_ready(ct_ready_a),
    .pt_valid(pt_valid_a), .pt_data(pt_data_a), .pt_ready(pt_ready),
    .done(done_a), .fail(fail_a)
  );

  arc4_stream_core #(.KEY_BYTES(4), .CHECK_ASCII(1), .MAX_LEN(255)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .rdy(rdy_b), .key(key_b), .halt(halt),
    .ct_valid(ct_valid), .ct_data(ct_data), .ct_ready(ct_ready_b),
    .pt_valid(pt_valid_b), .pt_data(pt_data_b), .pt_ready(pt_ready),
    .done(done_b), .fail(fail_b)
  );

  int         total = 0;
  int         bad = 0;
  logic [7:0] ct_mem [0:15];
  logic [7:0] exp_pt [0:15];
  logic [7:0] pt_got [0:15];
  int         ct_len, ct_idx, pt_cnt, stab_err;
  bit         src_on, sink_on, ct_rand, pt_rand;
  int         cycles, n;

  // Ciphertext source and plaintext sink; inputs change on the falling edge,
  // handshakes are sampled just before the rising edge.
  initial begin : io_proc
    bit         hold;
    logic [7:0] held;
    ct_idx = 0; pt_cnt = 0; stab_err = 0; hold = 0; held = 8'h00;
    ct_valid = 1'b0; ct_data = 8'h00; pt_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!src_on) begin
        ct_idx = 0;
        pt_cnt = 0;
      end
      ct_valid = src_on && (ct_idx < ct_len) && (!ct_rand || $urandom_range(0, 2) != 0);
      ct_data  = (ct_idx < ct_len) ? ct_mem[ct_idx] : 8'h00;
      pt_ready = sink_on && (!pt_rand || $urandom_range(0, 2) != 0);
      #4;
      if (hold && (!pt_valid || pt_data !== held)) stab_err++;
      hold = pt_valid && !pt_ready && !halt && rst_n;
      held = pt_data;
      if (ct_valid && ct_ready) ct_idx++;
      if (pt_valid && pt_ready && pt_cnt < 16) begin
        pt_got[pt_cnt] = pt_data;
        pt_cnt++;
      end
    end
  end

  initial begin : watchdog
    #800000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_vectors(input logic [127:0] ct, input logic [127:0] pt, input int len);
    for (int k = 0; k < 16; k++) begin
      ct_mem[k] = ct[127-8*k -: 8];
      exp_pt[k] = pt[127-8*k -: 8];
    end
    ct_len = len;
  endtask

  task automatic check_bytes(input string tag, input int cnt);
    for (int k = 0; k < cnt; k++)
      check_output($sformatf("%s[%0d]", tag, k), 32'(pt_got[k]), 32'(exp_pt[k]));
  endtask

  task automatic start_run(input logic [31:0] k);
    src_on = 1'b0;
    repeat (2) @(negedge clk);
    src_on = 1'b1;
    @(negedge clk);
    if (sel) key_b = k;
    else     key_a = k[23:0];
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
  endtask

  // Counts clock edges after the accepting edge until rdy returns; an en
  // pulse with a junk key is injected at cycle 'poke' when poke > 0.
  task automatic apply_stimulus(input logic [31:0] k, input int poke, output int cyc);
    start_run(k);
    cyc = 0;
    while (!rdy && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (cyc == poke) begin
        en    = 1'b1;
        key_a = 24'h000000;
        key_b = 32'h00000000;
      end else begin
        en = 1'b0;
      end
    end
    en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; halt = 1'b0; sel = 1'b0;
    key_a = '0; key_b = '0;
    src_on = 1'b0; sink_on = 1'b1; ct_rand = 1'b0; pt_rand = 1'b0; ct_len = 0;

    repeat (3) @(negedge clk);
    check_output("rst_rdy", 32'(rdy), 32'd1);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_fail", 32'(fail), 32'd0);
    check_output("rst_ct_ready", 32'(ct_ready), 32'd0);
    check_output("rst_pt_valid", 32'(pt_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // "Key" / "Plaintext", no stalls: 256 + 1024 + 2 + 9*5 + 1 cycles.
    load_vectors({80'h09BBF316E8D940AF0AD3, 48'h0}, {80'h09506C61696E74657874, 48'h0}, 10);
    apply_stimulus(32'h004B6579, 0, cycles);
    check_output("t1_cycles", 32'(cycles), 32'd1328);
    check_output("t1_done", 32'(done), 32'd1);
    check_output("t1_fail", 32'(fail), 32'd0);
    check_output("t1_pt_cnt", 32'(pt_cnt), 32'd10);
    check_output("t1_ct_used", 32'(ct_idx), 32'd10);
    check_bytes("t1_pt", 10);

    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    check_output("idle_halt_done", 32'(done), 32'd0);

    // First keystream byte for "Key" is EB, so ct 00 decrypts to EB.
    load_vectors({32'h09004141, 96'h0}, {8'h09, 120'h0}, 4);
    apply_stimulus(32'h004B6579, 0, cycles);
    check_output("t3_rdy", 32'(rdy), 32'd1);
    check_output("t3_done", 32'(done), 32'd1);
    check_output("t3_fail", 32'(fail), 32'd1);
    check_output("t3_ct_ready", 32'(ct_ready), 32'd0);
    check_output("t3_ct_used", 32'(ct_idx), 32'd2);
    check_output("t3_pt_cnt", 32'(pt_cnt), 32'd1);
    check_bytes("t3_pt", 1);

    load_vectors({8'h00, 120'h0}, {8'h00, 120'h0}, 1);
    apply_stimulus(32'h004B6579, 0, cycles);
    check_output("t4a_cycles", 32'(cycles), 32'd1282);
    check_output("t4a_done", 32'(done), 32'd1);
    check_output("t4a_fail", 32'(fail), 32'd0);
    check_output("t4a_pt_cnt", 32'(pt_cnt), 32'd1);
    check_bytes("t4a_pt", 1);

    load_vectors({8'h14, 120'h0}, 128'h0, 1);
    apply_stimulus(32'h004B6579, 0, cycles);
    check_output("t4b_cycles", 32'(cycles), 32'd1281);
    check_output("t4b_done", 32'(done), 32'd1);
    check_output("t4b_fail", 32'(fail), 32'd1);
    check_output("t4b_pt_cnt", 32'(pt_cnt), 32'd0);

    // "Wiki" / "pedia" on the 4-byte-key instance with random stalls.
    sel = 1'b1; ct_rand = 1'b1; pt_rand = 1'b1;
    load_vectors({48'h051021BF0420, 80'h0}, {48'h057065646961, 80'h0}, 6);
    apply_stimulus(32'h57696B69, 0, cycles);
    check_output("t2_rdy", 32'(rdy), 32'd1);
    check_output("t2_done", 32'(done), 32'd1);
    check_output("t2_fail", 32'(fail), 32'd0);
    check_output("t2_pt_cnt", 32'(pt_cnt), 32'd6);
    check_bytes("t2_pt", 6);
    check_output("t2_stable", 32'(stab_err), 32'd0);
    sel = 1'b0; ct_rand = 1'b0; pt_rand = 1'b0;

    load_vectors({80'h09BBF316E8D940AF0AD3, 48'h0}, {80'h09506C61696E74657874, 48'h0}, 10);
    start_run(32'h004B6579);
    repeat (600) @(negedge clk);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    check_output("t5_ksa_rdy", 32'(rdy), 32'd1);
    check_output("t5_ksa_done", 32'(done), 32'd0);
    check_output("t5_ksa_pt_valid", 32'(pt_valid), 32'd0);

    start_run(32'h004B6579);
    n = 0;
    while (pt_cnt < 4 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_output("t5_reach_prga", 32'(pt_cnt >= 4), 32'd1);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    check_output("t5_prga_rdy", 32'(rdy), 32'd1);
    check_output("t5_prga_done", 32'(done), 32'd0);
    check_output("t5_prga_pt_valid", 32'(pt_valid), 32'd0);
    check_output("t5_prga_ct_ready", 32'(ct_ready), 32'd0);

    apply_stimulus(32'h004B6579, 0, cycles);
    check_output("t5_rerun_cycles", 32'(cycles), 32'd1328);
    check_output("t5_rerun_done", 32'(done), 32'd1);
    check_output("t5_rerun_pt_cnt", 32'(pt_cnt), 32'd10);
    check_bytes("t5_rerun_pt", 10);

    start_run(32'h004B6579);
    n = 0;
    while (pt_cnt < 2 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    sink_on = 1'b0;
    repeat (12) @(negedge clk);
    check_output("t6_pending", 32'(pt_valid), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_output("t6_rdy", 32'(rdy), 32'd1);
    check_output("t6_done", 32'(done), 32'd0);
    check_output("t6_fail", 32'(fail), 32'd0);
    check_output("t6_ct_ready", 32'(ct_ready), 32'd0);
    check_output("t6_pt_valid", 32'(pt_valid), 32'd0);
    sink_on = 1'b1;

    apply_stimulus(32'h004B6579, 100, cycles);
    check_output("t6_busy_en_cycles", 32'(cycles), 32'd1328);
    check_output("t6_busy_en_done", 32'(done), 32'd1);
    check_output("t6_busy_en_fail", 32'(fail), 32'd0);
    check_output("t6_busy_en_pt_cnt", 32'(pt_cnt), 32'd10);
    check_bytes("t6_busy_en_pt", 10);
    check_output("final_stable", 32'(stab_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
